// File: rtl/dma_wr_burst_master.sv
// dma_wr_burst_master: buffers 64 B beats from the decompressor, cuts the page
// into AXI4 write bursts that never cross a 4 KB boundary, writes them to
// dst_address and pulses done once every burst has been acknowledged on B.
// Optional macro DMA_WR_TAIL_MASK_EN: mask the bytes past the page end on the
// final W beat instead of writing the whole beat.
module dma_wr_burst_master #(
    parameter int FIFO_DEPTH      = 16,
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDR_W          = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] dst_address,
    input  logic [31:0]       decompression_length,
    input  logic [511:0]      data_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [ADDR_W-1:0] m_awaddr,
    output logic [7:0]        m_awlen,
    output logic              m_awvalid,
    input  logic              m_awready,
    output logic [511:0]      m_wdata,
    output logic [63:0]       m_wstrb,
    output logic              m_wlast,
    output logic              m_wvalid,
    input  logic              m_wready,
    input  logic [1:0]        m_bresp,
    input  logic              m_bvalid,
    output logic              m_bready,
    output logic              busy,
    output logic              done,
    output logic              error
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);
    localparam int QP = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [PW:0]   DEPTH_C   = (PW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] MAXO_C    = CW'(MAX_OUTSTANDING);
    localparam logic [QP-1:0] LQ_LAST_C = QP'(MAX_OUTSTANDING - 1);

    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DRAIN = 2'd2} state_t;

    // Length-queue pointer advance; the queue depth need not be a power of two.
    function automatic logic [QP-1:0] lq_next(input logic [QP-1:0] p);
        if (p == LQ_LAST_C) lq_next = '0;
        else                lq_next = p + QP'(1);
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         aw_left_q, aw_left_d;
    logic [31:0]         w_left_q, w_left_d;
    logic [CW-1:0]       out_q, out_d;
    logic [PW:0]         cnt_q, cnt_d;
    logic [PW-1:0]       wptr_q, wptr_d, rptr_q, rptr_d;
    logic                rdy_q, rdy_d;
    logic                awvalid_q, awvalid_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [7:0]          awlen_q, awlen_d;
    logic [7:0]          lq_mem_q [2**QP];
    logic [7:0]          lq_mem_d [2**QP];
    logic [QP-1:0]       lq_wp_q, lq_wp_d, lq_rp_q, lq_rp_d;
    logic [CW-1:0]       lq_cnt_q, lq_cnt_d;
    logic [7:0]          beat_q, beat_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic [511:0]        mem_q [FIFO_DEPTH];

    logic                push_s, pop_s, aw_hs_s, b_dec_s, wlast_hs_s;
    logic [6:0]          room_s, blen_s;
    logic [31:0]         total_s;

    assign push_s     = valid_i & rdy_q;
    assign m_wvalid   = (cnt_q != '0) & (lq_cnt_q != '0);
    assign m_wlast    = (lq_cnt_q != '0) & (beat_q == lq_mem_q[lq_rp_q]);
    assign pop_s      = m_wvalid & m_wready;
    assign wlast_hs_s = pop_s & m_wlast;
    assign aw_hs_s    = awvalid_q & m_awready;
    assign b_dec_s    = m_bvalid & (out_q != '0);
    assign total_s    = {6'd0, decompression_length[31:6]} + {31'd0, |decompression_length[5:0]};
    assign room_s     = 7'd64 - {1'b0, addr_q[11:6]};
    assign blen_s     = (aw_left_q < {25'd0, room_s}) ? aw_left_q[6:0] : room_s;

    assign ready_o   = rdy_q;
    assign m_awaddr  = awaddr_q;
    assign m_awlen   = awlen_q;
    assign m_awvalid = awvalid_q;
    assign m_wdata   = mem_q[rptr_q];
    assign m_bready  = 1'b1;
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign error     = err_q;

`ifdef DMA_WR_TAIL_MASK_EN
    logic [5:0] tail_q;

    function automatic logic [63:0] tail_strb(input logic [5:0] t);
        tail_strb = (64'd1 << t) - 64'd1;
    endfunction

    // Remember the partial-beat byte count of the page being written.
    always_ff @(posedge clk) begin
        if (rst)                              tail_q <= 6'd0;
        else if (start && state_q == S_IDLE)  tail_q <= decompression_length[5:0];
        else                                  tail_q <= tail_q;
    end

    assign m_wstrb = (w_left_q == 32'd1 && tail_q != 6'd0) ? tail_strb(tail_q) : {64{1'b1}};
`else
    assign m_wstrb = {64{1'b1}};
`endif

    // Beat buffer storage; flushing is done through the pointers, not the data.
    always_ff @(posedge clk) begin
        if (push_s) mem_q[wptr_q] <= data_i;
    end

    // Next-state logic for the FIFO, AW issue, W tracking, B accounting and FSM.
    always_comb begin
        state_d = state_q;   addr_d = addr_q;       aw_left_d = aw_left_q;
        w_left_d = w_left_q; out_d = out_q;         cnt_d = cnt_q;
        wptr_d = wptr_q;     rptr_d = rptr_q;       awvalid_d = awvalid_q;
        awaddr_d = awaddr_q; awlen_d = awlen_q;     lq_mem_d = lq_mem_q;
        lq_wp_d = lq_wp_q;   lq_rp_d = lq_rp_q;     lq_cnt_d = lq_cnt_q;
        beat_d = beat_q;     done_d = 1'b0;         err_d = err_q;

        if (push_s) wptr_d = wptr_q + PW'(1);
        else        wptr_d = wptr_q;

        if (push_s && !pop_s)      cnt_d = cnt_q + (PW+1)'(1);
        else if (!push_s && pop_s) cnt_d = cnt_q - (PW+1)'(1);
        else                       cnt_d = cnt_q;

        if (pop_s) begin
            rptr_d   = rptr_q + PW'(1);
            w_left_d = w_left_q - 32'd1;
            if (m_wlast) begin
                beat_d  = 8'd0;
                lq_rp_d = lq_next(lq_rp_q);
            end else begin
                beat_d  = beat_q + 8'd1;
            end
        end else begin
            rptr_d = rptr_q;
        end

        // An accepted AW hands its length to the W side.
        if (aw_hs_s) begin
            awvalid_d          = 1'b0;
            lq_mem_d[lq_wp_q]  = awlen_q;
            lq_wp_d            = lq_next(lq_wp_q);
        end else begin
            lq_wp_d = lq_wp_q;
        end

        if (aw_hs_s && !wlast_hs_s)      lq_cnt_d = lq_cnt_q + CW'(1);
        else if (!aw_hs_s && wlast_hs_s) lq_cnt_d = lq_cnt_q - CW'(1);
        else                             lq_cnt_d = lq_cnt_q;

        if (aw_hs_s && !b_dec_s)      out_d = out_q + CW'(1);
        else if (!aw_hs_s && b_dec_s) out_d = out_q - CW'(1);
        else                          out_d = out_q;

        if (m_bvalid && m_bresp != 2'b00) err_d = 1'b1;
        else                              err_d = err_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    err_d = 1'b0;
                    if (total_s == 32'd0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d   = S_RUN;
                        addr_d    = dst_address;
                        aw_left_d = total_s;
                        w_left_d  = total_s;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                if (!awvalid_q && aw_left_q != 32'd0 && out_q < MAXO_C) begin
                    awvalid_d = 1'b1;
                    awaddr_d  = addr_q;
                    awlen_d   = {1'b0, blen_s - 7'd1};
                    addr_d    = addr_q + {{(ADDR_W-13){1'b0}}, blen_s, 6'd0};
                    aw_left_d = aw_left_q - {25'd0, blen_s};
                end else begin
                    awvalid_d = awvalid_d;
                end
                if (aw_left_q == 32'd0 && w_left_q == 32'd0) state_d = S_DRAIN;
                else                                         state_d = S_RUN;
            end
            S_DRAIN: begin
                if (out_q == '0) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: state_d = S_IDLE;
        endcase

        rdy_d = (state_d != S_IDLE) & (cnt_d < DEPTH_C);
    end

    // State register with synchronous reset; reset abandons any AXI traffic.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;  addr_q <= '0;     aw_left_q <= 32'd0;
            w_left_q <= 32'd0;  out_q <= '0;      cnt_q <= '0;
            wptr_q <= '0;       rptr_q <= '0;     rdy_q <= 1'b0;
            awvalid_q <= 1'b0;  awaddr_q <= '0;   awlen_q <= 8'd0;
            lq_mem_q <= '{default: 8'd0};
            lq_wp_q <= '0;      lq_rp_q <= '0;    lq_cnt_q <= '0;
            beat_q <= 8'd0;     done_q <= 1'b0;   err_q <= 1'b0;
        end else begin
            state_q <= state_d;   addr_q <= addr_d;     aw_left_q <= aw_left_d;
            w_left_q <= w_left_d; out_q <= out_d;       cnt_q <= cnt_d;
            wptr_q <= wptr_d;     rptr_q <= rptr_d;     rdy_q <= rdy_d;
            awvalid_q <= awvalid_d; awaddr_q <= awaddr_d; awlen_q <= awlen_d;
            lq_mem_q <= lq_mem_d;
            lq_wp_q <= lq_wp_d;   lq_rp_q <= lq_rp_d;   lq_cnt_q <= lq_cnt_d;
            beat_q <= beat_d;     done_q <= done_d;     err_q <= err_d;
        end
    end
endmodule

// File: tb/tb_dma_wr_burst_master.sv
// Directed bench for dma_wr_burst_master: aligned burst, 4 KB split,
// backpressure, outstanding limit, tail/error, zero length and mid-op reset.
module tb_dma_wr_burst_master;
    logic         clk = 1'b0;
    logic         rst, start, valid_i, ready_o;
    logic [63:0]  dst_address;
    logic [31:0]  decompression_length;
    logic [511:0] data_i;
    logic [63:0]  m_awaddr;
    logic [7:0]   m_awlen;
    logic         m_awvalid, m_awready;
    logic [511:0] m_wdata;
    logic [63:0]  m_wstrb;
    logic         m_wlast, m_wvalid, m_wready;
    logic [1:0]   m_bresp;
    logic         m_bvalid, m_bready, busy, done, error;

    dma_wr_burst_master #(.FIFO_DEPTH(16), .MAX_OUTSTANDING(4), .ADDR_W(64)) dut (
        .clk(clk), .rst(rst), .start(start), .dst_address(dst_address),
        .decompression_length(decompression_length), .data_i(data_i),
        .valid_i(valid_i), .ready_o(ready_o), .m_awaddr(m_awaddr), .m_awlen(m_awlen),
        .m_awvalid(m_awvalid), .m_awready(m_awready), .m_wdata(m_wdata),
        .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .busy(busy), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int aw_n, w_n, wl_n, b_given, done_n, src_total;
    logic [31:0] src_sent;
    logic b_auto, b_force, bv_seen;
    logic [63:0] aw_addr_log [0:31];
    logic [7:0]  aw_len_log  [0:31];
    logic [31:0] w_data_log  [0:1099];
    logic        w_last_log  [0:1099];
    logic [63:0] w_strb_log  [0:7];
    logic [63:0] exp_strb;
    int err_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: log handshakes mid-cycle, then drive source and B after the edge.
    task automatic cycle();
        #4;
        if (valid_i && ready_o) src_sent = src_sent + 32'd1;
        if (m_awvalid && m_awready) begin
            if (aw_n < 32) begin aw_addr_log[aw_n] = m_awaddr; aw_len_log[aw_n] = m_awlen; end
            aw_n++;
        end
        if (m_wvalid && m_wready) begin
            if (w_n < 1100) begin w_data_log[w_n] = m_wdata[31:0]; w_last_log[w_n] = m_wlast; end
            if (w_n < 8) w_strb_log[w_n] = m_wstrb;
            if (m_wlast) wl_n++;
            w_n++;
        end
        if (done) done_n++;
        bv_seen = m_bvalid;
        @(posedge clk);
        #1;
        if (bv_seen) b_given++;
        m_bvalid = (b_auto && (b_given < wl_n)) || b_force;
        b_force  = 1'b0;
        valid_i  = (src_sent < src_total);
        data_i   = {480'd0, src_sent};
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    task automatic wait_done(input int budget);
        for (int k = 0; k < budget && done_n == 0; k++) cycle();
    endtask

    task automatic kick(input logic [63:0] a, input logic [31:0] l);
        aw_n = 0; w_n = 0; wl_n = 0; b_given = 0; done_n = 0;
        src_sent = 32'd0; m_bvalid = 1'b0;
        src_total = int'(l >> 6) + ((l[5:0] != 6'd0) ? 1 : 0);
        dst_address = a; decompression_length = l;
        valid_i = (src_total > 0); data_i = 512'd0;
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    function automatic int order_errors(input int n);
        int e = 0;
        for (int i = 0; i < n && i < 1100; i++)
            if (w_data_log[i] !== 32'(i)) e++;
        return e;
    endfunction

    initial begin
        rst = 1'b1; start = 1'b0; valid_i = 1'b0; data_i = 512'd0;
        dst_address = 64'd0; decompression_length = 32'd0;
        m_awready = 1'b1; m_wready = 1'b1; m_bresp = 2'b00; m_bvalid = 1'b0;
        b_auto = 1'b1; b_force = 1'b0; src_total = 0; src_sent = 32'd0;
        aw_n = 0; w_n = 0; wl_n = 0; b_given = 0; done_n = 0;
        @(posedge clk); #1;
        run(2);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_error", {63'd0, error}, 64'd0);
        check("rst_awvalid", {63'd0, m_awvalid}, 64'd0);
        check("rst_wvalid", {63'd0, m_wvalid}, 64'd0);
        check("rst_ready", {63'd0, ready_o}, 64'd0);
        check("rst_bready", {63'd0, m_bready}, 64'd1);
        rst = 1'b0;
        run(1);

        // Aligned single 4 KB burst.
        kick(64'h1000, 32'd4096);
        check("t1_busy", {63'd0, busy}, 64'd1);
        wait_done(400);
        check("t1_done", 64'(done_n), 64'd1);
        check("t1_aw_n", 64'(aw_n), 64'd1);
        check("t1_awaddr", aw_addr_log[0], 64'h1000);
        check("t1_awlen", 64'(aw_len_log[0]), 64'd63);
        check("t1_w_n", 64'(w_n), 64'd64);
        check("t1_wlast_n", 64'(wl_n), 64'd1);
        check("t1_wlast64", {63'd0, w_last_log[63]}, 64'd1);
        check("t1_order", 64'(order_errors(64)), 64'd0);
        check("t1_b_before_done", 64'(b_given), 64'd1);
        run(3);
        check("t1_single_pulse", 64'(done_n), 64'd1);
        check("t1_idle", {63'd0, busy}, 64'd0);

        // Burst split at the 4 KB boundary.
        kick(64'h1FC0, 32'd256);
        wait_done(200);
        check("t2_done", 64'(done_n), 64'd1);
        check("t2_aw_n", 64'(aw_n), 64'd2);
        check("t2_aw0_addr", aw_addr_log[0], 64'h1FC0);
        check("t2_aw0_len", 64'(aw_len_log[0]), 64'd0);
        check("t2_aw1_addr", aw_addr_log[1], 64'h2000);
        check("t2_aw1_len", 64'(aw_len_log[1]), 64'd2);
        check("t2_wlast", {60'd0, w_last_log[3], w_last_log[2], w_last_log[1], w_last_log[0]}, 64'h9);
        check("t2_order", 64'(order_errors(4)), 64'd0);

        // W backpressure fills the FIFO; ready_o must drop at 16 entries.
        m_wready = 1'b0;
        kick(64'h0, 32'd2048);
        run(40);
        check("t3_accepted", 64'(src_sent), 64'd16);
        check("t3_ready_low", {63'd0, ready_o}, 64'd0);
        check("t3_no_w", 64'(w_n), 64'd0);
        m_wready = 1'b1;
        wait_done(300);
        check("t3_done", 64'(done_n), 64'd1);
        check("t3_w_n", 64'(w_n), 64'd32);
        check("t3_order", 64'(order_errors(32)), 64'd0);
        check("t3_awlen", 64'(aw_len_log[0]), 64'd31);

        // Outstanding limit with B withheld.
        b_auto = 1'b0;
        kick(64'h0, 32'd65536);
        run(300);
        check("t4_aw_limit", 64'(aw_n), 64'd4);
        check("t4_w_256", 64'(w_n), 64'd256);
        b_force = 1'b1;
        run(1);
        check("t4_no_5th_yet", 64'(aw_n), 64'd4);
        run(5);
        check("t4_5th_after_b", 64'(aw_n), 64'd5);
        b_auto = 1'b1;
        wait_done(3000);
        check("t4_done", 64'(done_n), 64'd1);
        check("t4_aw_n", 64'(aw_n), 64'd16);
        check("t4_w_n", 64'(w_n), 64'd1024);
        check("t4_order", 64'(order_errors(1024)), 64'd0);
        err_cnt = 0;
        for (int i = 0; i < 16; i++)
            if (aw_addr_log[i] !== 64'(i) * 64'd4096 || aw_len_log[i] !== 8'd63) err_cnt++;
        check("t4_aw_table", 64'(err_cnt), 64'd0);

        // Tail beat strobes and error response.
`ifdef DMA_WR_TAIL_MASK_EN
        exp_strb = 64'h0000_000F_FFFF_FFFF;
`else
        exp_strb = {64{1'b1}};
`endif
        m_bresp = 2'b10;
        kick(64'h3000, 32'd100);
        wait_done(100);
        check("t5_done", 64'(done_n), 64'd1);
        check("t5_w_n", 64'(w_n), 64'd2);
        check("t5_awlen", 64'(aw_len_log[0]), 64'd1);
        check("t5_strb0", w_strb_log[0], {64{1'b1}});
        check("t5_strb1", w_strb_log[1], exp_strb);
        check("t5_error", {63'd0, error}, 64'd1);
        m_bresp = 2'b00;
        run(2);
        check("t5_error_sticky", {63'd0, error}, 64'd1);

        // Zero length: done the cycle after start, no AXI traffic, error cleared.
        kick(64'h4000, 32'd0);
        check("t6_done", {63'd0, done}, 64'd1);
        check("t6_busy", {63'd0, busy}, 64'd0);
        check("t6_error_clr", {63'd0, error}, 64'd0);
        run(1);
        check("t6_done_pulse", {63'd0, done}, 64'd0);
        run(3);
        check("t6_no_aw", 64'(aw_n), 64'd0);

        // Reset in the middle of a burst.
        kick(64'h0, 32'd4096);
        run(20);
        rst = 1'b1;
        run(1);
        check("t7_busy", {63'd0, busy}, 64'd0);
        check("t7_awvalid", {63'd0, m_awvalid}, 64'd0);
        check("t7_wvalid", {63'd0, m_wvalid}, 64'd0);
        check("t7_ready", {63'd0, ready_o}, 64'd0);
        check("t7_done", {63'd0, done}, 64'd0);
        check("t7_error", {63'd0, error}, 64'd0);
        rst = 1'b0;
        src_total = 0;
        run(2);
        kick(64'h5000, 32'd128);
        wait_done(100);
        check("t7_after_done", 64'(done_n), 64'd1);
        check("t7_after_w", 64'(w_n), 64'd2);
        check("t7_after_order", 64'(order_errors(2)), 64'd0);
        check("t7_after_addr", aw_addr_log[0], 64'h5000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dma_wr_burst_master.md
Name: dma_wr_burst_master

Overview:
- Downstream consumer of the decompressed-data output stage.
- Accepts 64 B beats through a valid/ready handshake and buffers them in a small FIFO.
- Splits the page into AXI4 write bursts that never cross a 4 KB boundary, and writes the page to host memory at a programmed destination.
- Reports completion once every burst has received its write response.

Parameters:
- FIFO_DEPTH, 16, beat buffer depth in 512-bit entries; must be a power of 2, at least 4.
- MAX_OUTSTANDING, 4, maximum number of issued AW bursts still awaiting B.
- ADDR_W, 64, AXI address width.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; latches dst_address and decompression_length.
- dst_address  in  ADDR_W  destination byte address; must be 64 B aligned.
- decompression_length  in  32  page length in bytes.
- data_i  in  512  beat data.
- valid_i  in  1  beat valid.
- ready_o  out  1  beat accepted when valid_i&ready_o.
- m_awaddr  out  ADDR_W  burst address.
- m_awlen  out  8  beats-1.
- m_awvalid  out  1  AW valid.
- m_awready  in  1  AW ready.
- m_wdata  out  512  write data.
- m_wstrb  out  64  byte strobes.
- m_wlast  out  1  last beat of burst.
- m_wvalid  out  1  W valid.
- m_wready  in  1  W ready.
- m_bresp  in  2  write response.
- m_bvalid  in  1  B valid.
- m_bready  out  1  tied high.
- busy  out  1  page in progress.
- done  out  1  one-cycle pulse when all B responses are received.
- error  out  1  sticky until next start; set if any bresp!=0.

Behaviour:
- Reset values:
  - all valids, busy, done and error are 0; m_bready is 1.
  - FIFO is empty and all counters are 0.
  - ready_o is 0.
- total_beats = ceil(decompression_length/64), computed as len[31:6] + |len[5:0]. A length of 0 gives done one cycle after start with no AXI traffic.
- FIFO:
  - push on valid_i&ready_o; pop on m_wvalid&m_wready.
  - ready_o = busy & (count < FIFO_DEPTH). It is registered, so it deasserts one cycle early: at count >= FIFO_DEPTH-1 while a push occurs without a pop. No overflow is permitted.
  - Beats arriving while not busy are not accepted.
- AW issue. Next burst length = min(64 - next_addr[11:6], aw_beats_left). next_addr starts at dst_address and advances by 64*beats.
  - m_awvalid is held, with stable address and length, until m_awready.
  - A new AW is issued only while outstanding < MAX_OUTSTANDING.
  - outstanding increments on the AW handshake and decrements on the B handshake. When both happen in the same cycle it is unchanged.
- W channel:
  - Burst lengths from accepted AWs are queued in a MAX_OUTSTANDING-deep length queue.
  - m_wvalid = FIFO not empty & length queue not empty.
  - m_wlast is asserted when the beat counter equals the head length-1. The head is popped on the wlast handshake.
  - W may not precede its AW handshake.
- States:
  - IDLE: start → RUN.
  - RUN: when aw_beats_left==0 and w_beats_left==0 → DRAIN.
  - DRAIN: outstanding==0 → pulse done, return to IDLE.
  - start is ignored outside IDLE.
- busy = state!=IDLE.
- B responses: any nonzero bresp sets error. The block still completes normally.
- Reset mid-operation:
  - all state returns to IDLE and the FIFO is flushed.
  - outstanding AXI transactions are abandoned; the bus fabric is reset with this block.
- wstrb is all ones unless the optional feature below is enabled.

Optional Feature:
- DMA_WR_TAIL_MASK_EN.
- Defined: on the final beat of the page, m_wstrb = (64'b1 << len[5:0]) - 1 when len[5:0]!=0, so bytes past the page end are not written.
- Undefined: m_wstrb is always all ones; the tail bytes of the last beat are written with whatever data_i carries.

Test Plan:
- Aligned single burst: dst=0x1000, len=4096, continuous valid_i, always-ready slave → one AW with awlen=63; 64 W beats with wlast on beat 64; done pulse after B.
- 4 KB split: dst=0x1FC0, len=256 → AW0 addr 0x1FC0 awlen=0; AW1 addr 0x2000 awlen=2; wlast on beats 1 and 4.
- Backpressure: m_wready low for 40 cycles with FIFO_DEPTH=16 → ready_o drops at 16 entries; no beat lost or duplicated; data order preserved.
- Outstanding limit: len=64 KB, m_bvalid withheld → exactly 4 AWs issued; the 5th is issued only after the first B.
- Tail and error: len=100, DMA_WR_TAIL_MASK_EN defined → 2 beats, last wstrb=0x0000000F_FFFFFFFF (36 B). Returning bresp=2 on B → error=1 and done still pulses.
- Zero length and mid-op reset: len=0 → done one cycle after start with no AW. rst asserted during a burst → all outputs return to reset values the next cycle.
